reg_writeback_arbiter: RTL and testbench

//   Write-side master for the 32x32 register file: merges in-order pipeline writebacks with

---
 rtl/reg_writeback_arbiter_pkg.sv | 14 +
 rtl/reg_writeback_arbiter_pending_queue.sv | 83 ++++++++
 rtl/reg_writeback_arbiter.sv | 92 +++++++++
 tb/tb_reg_writeback_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared widths and the pending-queue entry type for the register-file write-side arbiter.
package reg_writeback_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              kill;
   } wb_entry_t;

endpackage

// File: rtl/reg_writeback_arbiter_pending_queue.sv
// Pending queue for long-latency results: circular storage with per-entry kill bits,
// a kill CAM for write-after-write squashing and a lookup CAM for the hazard unit.
module wb_pending_queue
   import reg_writeback_arbiter_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push_i,
   input  wb_entry_t         push_entry_i,
   input  logic              pop_i,
   input  logic              kill_en_i,
   input  logic [ADDR_W-1:0] kill_addr_i,
   input  logic [ADDR_W-1:0] query_addr_i,
   output wb_entry_t         head_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              query_pend_o
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = $clog2(QDEPTH + 1);

   logic [ADDR_W-1:0] addr_q [QDEPTH];
   logic [DATA_W-1:0] data_q [QDEPTH];
   logic [QDEPTH-1:0] vld_q;
   logic [QDEPTH-1:0] kill_q;
   logic [PTR_W-1:0]  rd_q;
   logic [PTR_W-1:0]  wr_q;
   logic [CNT_W-1:0]  cnt_q;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(QDEPTH));
   assign head_o  = '{addr: addr_q[rd_q], data: data_q[rd_q], kill: kill_q[rd_q]};

   // Control state; the push slot is never valid, so the kill sweep cannot race the push write.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         vld_q  <= '0;
         kill_q <= '0;
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (kill_en_i && vld_q[i] && (addr_q[i] == kill_addr_i)) begin
               kill_q[i] <= 1'b1;
            end
         end
         if (pop_i) begin
            vld_q[rd_q] <= 1'b0;
            rd_q        <= rd_q + PTR_W'(1);
         end
         if (push_i) begin
            vld_q[wr_q]  <= 1'b1;
            kill_q[wr_q] <= push_entry_i.kill;
            wr_q         <= wr_q + PTR_W'(1);
         end
         cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         addr_q[wr_q] <= push_entry_i.addr;
         data_q[wr_q] <= push_entry_i.data;
      end
   end

   always_comb begin
      query_pend_o = 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
         if (vld_q[i] && !kill_q[i] && (addr_q[i] == query_addr_i)) begin
            query_pend_o = 1'b1;
         end
      end
      if (query_addr_i == REG_ZERO) begin
         query_pend_o = 1'b0;
      end
   end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Single RF write port master: pipeline writebacks always win, long-latency results
// queue up and drain into idle slots; younger pipeline writes squash queued ones.
module reg_writeback_arbiter
   import reg_writeback_arbiter_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              pipe_wen,
   input  logic [ADDR_W-1:0] pipe_waddr,
   input  logic [DATA_W-1:0] pipe_wdata,
   input  logic              lu_valid,
   output logic              lu_ready,
   input  logic [ADDR_W-1:0] lu_addr,
   input  logic [DATA_W-1:0] lu_data,
   input  logic [ADDR_W-1:0] query_addr,
   output logic              query_pend,
   output logic              rf_wen,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   logic              slot_busy;
   logic              q_full;
   logic              q_empty;
   logic              q_push;
   logic              q_pop;
   logic              q_pend;
   wb_entry_t         push_entry;
   wb_entry_t         head;
   logic              rf_wen_q, rf_wen_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

   assign slot_busy = pipe_wen && (pipe_waddr != REG_ZERO);
   // Readiness looks only at the registered count, so no lu_valid -> lu_ready path exists.
   assign lu_ready  = rstn && !q_full;
   assign q_push    = lu_valid && lu_ready && (lu_addr != REG_ZERO);
   assign push_entry = '{addr: lu_addr, data: lu_data,
                         kill: slot_busy && (lu_addr == pipe_waddr)};
   // A killed head leaves even when the port is taken; it never needs the port.
   assign q_pop     = !q_empty && (!slot_busy || head.kill);
   assign query_pend = rstn && q_pend;

   wb_pending_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk          (clk),
      .rstn         (rstn),
      .push_i       (q_push),
      .push_entry_i (push_entry),
      .pop_i        (q_pop),
      .kill_en_i    (slot_busy),
      .kill_addr_i  (pipe_waddr),
      .query_addr_i (query_addr),
      .head_o       (head),
      .empty_o      (q_empty),
      .full_o       (q_full),
      .query_pend_o (q_pend)
   );

   always_comb begin
      rf_wen_d   = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (slot_busy) begin
         rf_wen_d   = 1'b1;
         rf_waddr_d = pipe_waddr;
         rf_wdata_d = pipe_wdata;
      end else if (q_pop && !head.kill) begin
         rf_wen_d   = 1'b1;
         rf_waddr_d = head.addr;
         rf_wdata_d = head.data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter: priority, draining, back-pressure, kill and query.
module tb_reg_writeback_arbiter;
   import reg_writeback_arbiter_pkg::*;

   logic              clk = 1'b0;
   logic              rstn;
   logic              pipe_wen;
   logic [ADDR_W-1:0] pipe_waddr;
   logic [DATA_W-1:0] pipe_wdata;
   logic              lu_valid;
   logic              lu_ready;
   logic [ADDR_W-1:0] lu_addr;
   logic [DATA_W-1:0] lu_data;
   logic [ADDR_W-1:0] query_addr;
   logic              query_pend;
   logic              rf_wen;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_writeback_arbiter #(.QDEPTH(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .pipe_wen   (pipe_wen),
      .pipe_waddr (pipe_waddr),
      .pipe_wdata (pipe_wdata),
      .lu_valid   (lu_valid),
      .lu_ready   (lu_ready),
      .lu_addr    (lu_addr),
      .lu_data    (lu_data),
      .query_addr (query_addr),
      .query_pend (query_pend),
      .rf_wen     (rf_wen),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pipe(input logic we, input int a, input int d);
      pipe_wen   = we;
      pipe_waddr = ADDR_W'(a);
      pipe_wdata = DATA_W'(d);
   endtask

   task automatic set_lu(input logic v, input int a, input int d);
      lu_valid = v;
      lu_addr  = ADDR_W'(a);
      lu_data  = DATA_W'(d);
   endtask

   task automatic check_rf(input string tag, input logic we, input int a, input int d);
      check({tag, ".wen"}, 64'(rf_wen), 64'(we));
      check({tag, ".addr"}, 64'(rf_waddr), 64'(a));
      check({tag, ".data"}, 64'(rf_wdata), 64'(d));
   endtask

   initial begin
      int idx;
      rstn = 1'b0;
      set_pipe(1'b0, 0, 0);
      set_lu(1'b1, 4, 32'h44);
      query_addr = 5'd4;

      // 1: reset with an offered LU result
      tick();
      tick();
      check_rf("rst", 1'b0, 0, 0);
      check("rst.ready", 64'(lu_ready), 64'd0);
      check("rst.pend", 64'(query_pend), 64'd0);
      set_lu(1'b0, 0, 0);
      rstn = 1'b1;
      #1;
      check("post_rst.ready", 64'(lu_ready), 64'd1);
      check("post_rst.pend", 64'(query_pend), 64'd0);

      // 2: pipe only, r0 write suppressed
      set_pipe(1'b1, 3, 32'h11);
      tick();
      check_rf("pipe_r3", 1'b1, 3, 32'h11);
      set_pipe(1'b1, 0, 32'h22);
      tick();
      check_rf("pipe_r0", 1'b0, 3, 32'h11);
      set_pipe(1'b0, 0, 0);

      // 3: drain two LU results
      set_lu(1'b1, 5, 32'hAA);
      tick();
      check("drain.c0.wen", 64'(rf_wen), 64'd0);
      set_lu(1'b1, 6, 32'hBB);
      tick();
      check_rf("drain.r5", 1'b1, 5, 32'hAA);
      set_lu(1'b0, 0, 0);
      tick();
      check_rf("drain.r6", 1'b1, 6, 32'hBB);
      tick();
      check("drain.idle.wen", 64'(rf_wen), 64'd0);

      // 4: pipe busy for six cycles while five LU results arrive
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         set_pipe(1'b1, 1, 32'h100 + c);
         set_lu(idx < 5, 10 + idx, 32'hA0 + idx);
         #1;
         check($sformatf("full.ready.c%0d", c), 64'(lu_ready), (c < 4) ? 64'd1 : 64'd0);
         if (lu_ready) idx++;
         tick();
         check_rf($sformatf("full.pipe.c%0d", c), 1'b1, 1, 32'h100 + c);
      end
      set_pipe(1'b0, 0, 0);
      for (int c = 0; c < 5; c++) begin
         set_lu(idx < 5, 10 + idx, 32'hA0 + idx);
         #1;
         check($sformatf("drain4.ready.c%0d", c), 64'(lu_ready), (c == 0) ? 64'd0 : 64'd1);
         if (lu_ready && lu_valid) idx++;
         tick();
         check_rf($sformatf("drain4.c%0d", c), 1'b1, 10 + c, 32'hA0 + c);
      end
      set_lu(1'b0, 0, 0);
      tick();
      check("drain4.empty.wen", 64'(rf_wen), 64'd0);

      // 5: kill of a queued entry by a younger pipe write
      set_lu(1'b1, 7, 32'h1);
      set_pipe(1'b1, 8, 32'h55);
      tick();
      check_rf("kill.r8", 1'b1, 8, 32'h55);
      set_lu(1'b0, 0, 0);
      set_pipe(1'b1, 7, 32'h2);
      query_addr = 5'd7;
      #1;
      check("kill.pend_before", 64'(query_pend), 64'd1);
      tick();
      check_rf("kill.r7", 1'b1, 7, 32'h2);
      check("kill.pend_after", 64'(query_pend), 64'd0);
      set_pipe(1'b0, 0, 0);
      tick();
      check_rf("kill.discard", 1'b0, 7, 32'h2);
      tick();
      check("kill.empty.wen", 64'(rf_wen), 64'd0);
      set_lu(1'b1, 7, 32'h3);
      set_pipe(1'b1, 7, 32'h4);
      tick();
      check_rf("samecyc.r7", 1'b1, 7, 32'h4);
      check("samecyc.pend", 64'(query_pend), 64'd0);
      set_lu(1'b0, 0, 0);
      set_pipe(1'b0, 0, 0);
      tick();
      check_rf("samecyc.discard", 1'b0, 7, 32'h4);
      tick();
      check("samecyc.empty.wen", 64'(rf_wen), 64'd0);

      // 6: query behaviour
      set_lu(1'b1, 9, 32'h99);
      set_pipe(1'b1, 1, 32'h5);
      tick();
      check_rf("query.r1", 1'b1, 1, 32'h5);
      set_lu(1'b0, 0, 0);
      query_addr = 5'd9;
      #1;
      check("query.pend9", 64'(query_pend), 64'd1);
      query_addr = 5'd0;
      #1;
      check("query.pend0", 64'(query_pend), 64'd0);
      query_addr = 5'd9;
      set_pipe(1'b0, 0, 0);
      #1;
      check("query.pend_popping", 64'(query_pend), 64'd1);
      tick();
      check_rf("query.r9", 1'b1, 9, 32'h99);
      check("query.pend_gone", 64'(query_pend), 64'd0);
      set_lu(1'b1, 9, 32'h9A);
      set_pipe(1'b1, 1, 32'h6);
      tick();
      set_lu(1'b0, 0, 0);
      set_pipe(1'b1, 9, 32'h7);
      #1;
      check("query.pend_live", 64'(query_pend), 64'd1);
      tick();
      check("query.pend_killed", 64'(query_pend), 64'd0);
      set_pipe(1'b0, 0, 0);
      tick();
      check_rf("query.discard", 1'b0, 9, 32'h7);

      // LU result to r0 completes the handshake but stores nothing
      set_lu(1'b1, 0, 32'hDEAD);
      #1;
      check("r0.ready", 64'(lu_ready), 64'd1);
      tick();
      set_lu(1'b0, 0, 0);
      tick();
      check("r0.wen", 64'(rf_wen), 64'd0);
      tick();
      check("r0.wen2", 64'(rf_wen), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
